// File: rtl/polymul_seq.sv
// Sequential polynomial multiplier: c = a*b mod (x^N - 1), coefficients mod 2^W,
// built from a rotating a-register and N MAC lanes. Define POLYMUL_NEGACYCLIC_EN for mod (x^N + 1).
module polymul_seq #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             ready,
  input  logic [N*W-1:0]                   a_in,
  input  logic [N*W-1:0]                   b_in,
  output logic                             busy,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] step,
  output logic [N*W-1:0]                   c_out,
  output logic                             out_valid,
  input  logic                             out_ready
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [W-1:0]   r_rot [N];
  logic [W-1:0]   r_b   [N];
  logic [W-1:0]   r_acc [N];
  logic [W-1:0]   w_rot_nxt [N];
  logic [W-1:0]   w_bk;
  logic [KW-1:0]  r_k;
  logic           r_out_valid;
  logic [N*W-1:0] r_c_out;
  logic           w_last;

  assign w_last = (r_k == KW'(N - 1));
  assign w_bk   = r_b[r_k];

  always_comb begin
    for (int unsigned j = 1; j < N; j++) begin
      w_rot_nxt[j] = r_rot[j-1];
    end
`ifdef POLYMUL_NEGACYCLIC_EN
    w_rot_nxt[0] = -r_rot[N-1];
`else
    w_rot_nxt[0] = r_rot[N-1];
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The result is registered on the first DONE cycle, so out_valid rises N+2 edges after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_c_out     <= '0;
      for (int unsigned j = 0; j < N; j++) begin
        r_rot[j] <= '0;
        r_b[j]   <= '0;
        r_acc[j] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k <= '0;
            for (int unsigned j = 0; j < N; j++) begin
              r_rot[j] <= a_in[j*W +: W];
              r_b[j]   <= b_in[j*W +: W];
              r_acc[j] <= '0;
            end
          end
        end
        S_LOAD: r_k <= '0;
        S_RUN: begin
          for (int unsigned j = 0; j < N; j++) begin
            r_acc[j] <= r_acc[j] + r_rot[j] * w_bk;
            r_rot[j] <= w_rot_nxt[j];
          end
          r_k <= w_last ? '0 : r_k + 1'b1;
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            for (int unsigned j = 0; j < N; j++) begin
              r_c_out[j*W +: W] <= r_acc[j];
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_LOAD) || (r_state == S_RUN);
  assign step      = (r_state == S_RUN) ? r_k : '0;
  assign c_out     = r_c_out;
  assign out_valid = r_out_valid;

endmodule
